// File: rtl/button_event.sv
// Button event classifier: turns a debounced button level into press, release,
// long-press and auto-repeat pulses, and counts presses plus repeats for display.
module button_event #(
  parameter int LONG_TICKS   = 1024,
  parameter int REPEAT_TICKS = 256
) (
  input  logic       clk_1024,
  input  logic       reset_n,
  input  logic       prell_flag,
  input  logic       event_en,
  input  logic       count_clr,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       long_active,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LONG
  } state_e;

  // hold_cnt restarts at 0 on each deadline, so a deadline is reached one tick before the target
  localparam logic [10:0] LongLast   = 11'(LONG_TICKS - 1);
  localparam logic [10:0] RepeatLast = 11'(REPEAT_TICKS - 1);

  state_e      state_q, state_d;
  logic [10:0] hold_cnt_q, hold_cnt_d;
  logic        prev_flag_q;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;
  logic        long_active_q, long_active_d;
  logic [7:0]  count_q, count_d;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;

    if (!event_en) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (prell_flag && !prev_flag_q) begin
            press_d    = 1'b1;
            hold_cnt_d = '0;
            state_d    = PRESSED;
          end
        end
        PRESSED: begin
          if (!prell_flag) begin
            release_d  = 1'b1;
            hold_cnt_d = '0;
            state_d    = IDLE;
          end else if (hold_cnt_q == LongLast) begin
            long_d     = 1'b1;
            hold_cnt_d = '0;
            state_d    = LONG;
          end else begin
            hold_cnt_d = hold_cnt_q + 11'd1;
          end
        end
        LONG: begin
          if (!prell_flag) begin
            release_d  = 1'b1;
            hold_cnt_d = '0;
            state_d    = IDLE;
          end else if (hold_cnt_q == RepeatLast) begin
            repeat_d   = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 11'd1;
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end

    long_active_d = (state_d == LONG);

    // Clear beats increment, so a clear on a press edge leaves the count at zero
    if (count_clr) begin
      count_d = '0;
    end else if (press_d || repeat_d) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk_1024) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      prev_flag_q   <= 1'b0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      long_q        <= 1'b0;
      repeat_q      <= 1'b0;
      long_active_q <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      prev_flag_q   <= prell_flag;
      press_q       <= press_d;
      release_q     <= release_d;
      long_q        <= long_d;
      repeat_q      <= repeat_d;
      long_active_q <= long_active_d;
      count_q       <= count_d;
    end
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign long_active   = long_active_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: a time-based reference model queues the
// expected outputs per edge and a monitor pops and compares them after each edge.
module tb_button_event;

  localparam int LongTicks   = 8;
  localparam int RepeatTicks = 4;

  logic       clk_1024 = 1'b0;
  logic       reset_n = 1'b0;
  logic       prell_flag = 1'b0;
  logic       event_en = 1'b0;
  logic       count_clr = 1'b0;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       repeat_pulse;
  logic       long_active;
  logic [7:0] press_count;

  always #5 clk_1024 = ~clk_1024;

  button_event #(
    .LONG_TICKS  (LongTicks),
    .REPEAT_TICKS(RepeatTicks)
  ) dut (
    .clk_1024     (clk_1024),
    .reset_n      (reset_n),
    .prell_flag   (prell_flag),
    .event_en     (event_en),
    .count_clr    (count_clr),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .long_active  (long_active),
    .press_count  (press_count)
  );

  typedef struct {
    int         cyc;
    logic       pressP;
    logic       releaseP;
    logic       longP;
    logic       repeatP;
    logic       longAct;
    logic [7:0] count;
  } expect_t;

  expect_t expQ[$];
  int      checks = 0;
  int      failures = 0;
  bit      stimDone = 1'b0;

  // Reference model: a press is described by the edge it started on, and every
  // event is derived from the number of edges elapsed since then.
  int         cycleNo = 0;
  int         pressStart = 0;
  bit         pressing = 1'b0;
  bit         prevFlag = 1'b0;
  logic [7:0] modelCount = 8'd0;

  task automatic applyStimulus(input logic rstN, input logic en, input logic flag, input logic clr);
    expect_t e;
    int      held;
    @(negedge clk_1024);
    reset_n    = rstN;
    event_en   = en;
    prell_flag = flag;
    count_clr  = clr;
    cycleNo++;
    e.cyc      = cycleNo;
    e.pressP   = 1'b0;
    e.releaseP = 1'b0;
    e.longP    = 1'b0;
    e.repeatP  = 1'b0;
    e.longAct  = 1'b0;
    if (!rstN) begin
      pressing   = 1'b0;
      prevFlag   = 1'b0;
      modelCount = 8'd0;
      e.count    = 8'd0;
    end else begin
      if (!en) begin
        pressing = 1'b0;
      end else if (pressing) begin
        if (!flag) begin
          e.releaseP = 1'b1;
          pressing   = 1'b0;
        end else begin
          held = cycleNo - pressStart;
          if (held == LongTicks) e.longP = 1'b1;
          else if (held > LongTicks && (held - LongTicks) % RepeatTicks == 0) e.repeatP = 1'b1;
        end
      end else if (flag && !prevFlag) begin
        e.pressP   = 1'b1;
        pressing   = 1'b1;
        pressStart = cycleNo;
      end
      e.longAct = pressing && ((cycleNo - pressStart) >= LongTicks);
      if (clr) modelCount = 8'd0;
      else if (e.pressP || e.repeatP) modelCount = modelCount + 8'd1;
      e.count  = modelCount;
      prevFlag = flag;
    end
    expQ.push_back(e);
  endtask

  task automatic holdFlag(input logic flag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, flag, 1'b0);
  endtask

  task automatic checkOutput(input expect_t e);
    logic [12:0] act;
    logic [12:0] req;
    act = {press_pulse, release_pulse, long_pulse, repeat_pulse, long_active, press_count};
    req = {e.pressP, e.releaseP, e.longP, e.repeatP, e.longAct, e.count};
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL edge%0d {press,release,long,repeat,active,count}: got %b_%b_%b_%b_%b_%0d required %b_%b_%b_%b_%b_%0d",
               e.cyc, act[12], act[11], act[10], act[9], act[8], act[7:0],
               req[12], req[11], req[10], req[9], req[8], req[7:0]);
    end
  endtask

  initial begin
    expect_t e;
    while (!stimDone) begin
      @(posedge clk_1024);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d unchecked entries required 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic randFlag;
    logic randRst;
    logic randEn;
    logic randClr;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    holdFlag(1'b0, 2);

    $display("[TB] short press");
    holdFlag(1'b1, 3);
    holdFlag(1'b0, 3);

    $display("[TB] long hold with repeats");
    holdFlag(1'b1, 20);
    holdFlag(1'b0, 3);

    $display("[TB] release on long deadline");
    holdFlag(1'b1, 8);
    holdFlag(1'b0, 3);

    $display("[TB] enable gating");
    holdFlag(1'b1, 5);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    holdFlag(1'b1, 4);
    holdFlag(1'b0, 2);
    holdFlag(1'b1, 2);
    holdFlag(1'b0, 2);

    $display("[TB] counter wrap and clear");
    for (int i = 0; i < 256; i++) begin
      holdFlag(1'b1, 1);
      holdFlag(1'b0, 1);
    end
    holdFlag(1'b1, 1);
    holdFlag(1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    holdFlag(1'b0, 2);

    $display("[TB] reset during long hold");
    holdFlag(1'b1, 10);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    holdFlag(1'b1, 3);
    holdFlag(1'b0, 2);

    $display("[TB] randomized traffic");
    randFlag = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(14, 0) == 0) randFlag = ~randFlag;
      randRst = ($urandom_range(299, 0) != 0);
      randEn  = ($urandom_range(49, 0) != 0);
      randClr = ($urandom_range(39, 0) == 0);
      applyStimulus(randRst, randEn, randFlag, randClr);
    end

    stimDone = 1'b1;
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter LONG_TICKS, default 1024, meaning clock edges a press is held before it is classed as long (1 s at 1024 Hz); legal range 2..2047.
REQ-002 SHALL have parameter REPEAT_TICKS, default 256, meaning clock edges between auto-repeat pulses while a long press is held; legal range 1..2047.
REQ-003 SHALL have port clk_1024  input  1  system clock (1024 Hz); all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port prell_flag  input  1  debounced button level from the debounce stage, synchronous to clk_1024; 1 = pressed.
REQ-006 SHALL have port event_en  input  1  event detection enable.
REQ-007 SHALL have port count_clr  input  1  synchronous clear of press_count.
REQ-008 SHALL have port press_pulse  output  1  one-cycle pulse on each new press.
REQ-009 SHALL have port release_pulse  output  1  one-cycle pulse on each release.
REQ-010 SHALL have port long_pulse  output  1  one-cycle pulse when a press becomes long.
REQ-011 SHALL have port repeat_pulse  output  1  one-cycle auto-repeat pulse during a long press.
REQ-012 SHALL have port long_active  output  1  level, high while in state LONG.
REQ-013 SHALL have port press_count  output  8  count of press_pulse plus repeat_pulse events, for LCD display.

Function
REQ-014 All outputs SHALL be registered; prell_flag SHALL be registered once into prev_flag for edge detection.
REQ-015 The FSM SHALL have states IDLE, PRESSED and LONG, plus an 11-bit hold counter hold_cnt.
REQ-016 Edge k is the first edge with event_en=1, prev_flag=0 and prell_flag=1; in IDLE at edge k: press_pulse=1 for exactly one cycle, hold_cnt=0, state goes to PRESSED.
REQ-017 In PRESSED, while prell_flag=1: hold_cnt increments each edge; at edge k+LONG_TICKS: long_pulse=1 for one cycle, long_active=1, hold_cnt=0, state goes to LONG.
REQ-018 In LONG, while prell_flag=1: hold_cnt increments; at edges k+LONG_TICKS+n*REPEAT_TICKS (n>=1): repeat_pulse=1 for one cycle, hold_cnt=0.
REQ-019 In PRESSED or LONG, the first edge sampling prell_flag=0: release_pulse=1 for one cycle, long_active=0, hold_cnt=0, state goes to IDLE.
REQ-020 If release coincides with a long or repeat deadline, release SHALL win: no long_pulse or repeat_pulse that edge.
REQ-021 A one-cycle press (high at edge k, low at k+1) SHALL give press_pulse at k and release_pulse at k+1.
REQ-022 If event_en=0 at any edge: state goes to IDLE, hold_cnt=0, all pulse outputs and long_active go to 0, press_count is held, and prev_flag still tracks prell_flag.
REQ-023 Re-enabling while prell_flag is held high SHALL NOT produce press_pulse; a fresh 0->1 transition is required.
REQ-024 press_count SHALL increment by 1 at each edge that asserts press_pulse or repeat_pulse, wrapping from 255 to 0.
REQ-025 press_count priority SHALL be reset > count_clr > increment; count_clr together with an increment gives 0.
REQ-026 At most one of press_pulse, release_pulse, long_pulse or repeat_pulse SHALL be high in any cycle.

Reset
REQ-027 At an edge with reset_n=0: state=IDLE, hold_cnt=0, prev_flag=0, press_count=0, and all outputs 0; this overrides every other input.
REQ-028 Reset mid-press SHALL abort with no release_pulse; if prell_flag is still 1 at the first edge after reset releases, that edge counts as a new press (prev_flag=0).

Verification (use LONG_TICKS=8, REPEAT_TICKS=4)
REQ-029 Short press: prell_flag high for 3 edges -> press_pulse at k, release_pulse at k+3, press_count=1, no long_pulse.
REQ-030 Long hold: prell_flag high for 20 edges -> press_pulse at k, long_pulse at k+8, repeat_pulse at k+12 and k+16, release_pulse at k+20, press_count=3.
REQ-031 Release on deadline: prell_flag falls so the first 0 is sampled at k+8 -> release_pulse at k+8, no long_pulse.
REQ-032 Enable gating: with press held, drop event_en at k+5 for 2 edges, then restore -> all outputs 0, no new press_pulse until prell_flag toggles 0->1.
REQ-033 Counter: 256 short presses -> press_count wraps to 0; count_clr on the same edge as a press_pulse -> press_count=0.
REQ-034 Reset at k+10 of a long hold with prell_flag still 1 -> outputs 0 during reset; press_pulse at the first edge after reset_n returns to 1.
